// File: rtl/onewire_pkg.sv
// Shared op encodings, FSM state type and default standard-speed timing for the 1-wire bit master.
package onewire_pkg;

  localparam logic [1:0] OP_RST = 2'd0;
  localparam logic [1:0] OP_WR0 = 2'd1;
  localparam logic [1:0] OP_WR1 = 2'd2;
  localparam logic [1:0] OP_RD  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_DONE
  } state_e;

  localparam int US_W = 10;

  localparam int DEF_FRQ    = 50000000;
  localparam int DEF_T_RSTL = 480;
  localparam int DEF_T_PDS  = 70;
  localparam int DEF_T_RSTH = 480;
  localparam int DEF_T_LOW0 = 60;
  localparam int DEF_T_LOW1 = 6;
  localparam int DEF_T_SMP  = 15;
  localparam int DEF_T_SLOT = 70;

endpackage

// File: rtl/onewire_clkdiv.sv
// Microsecond prescaler: tick_o is high on the last clock of each CDR-clock period.
// Restarts from zero on clr_i so a slot's first microsecond is a full period.
module onewire_clkdiv
  import onewire_pkg::*;
#(
  parameter int CDR = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);

  localparam int PW = (CDR > 1) ? $clog2(CDR) : 1;

  logic [PW-1:0] pre_q, pre_d;

  assign tick_o = (pre_q == PW'(CDR - 1));

  always_comb begin
    pre_d = pre_q + PW'(1);
    if (clr_i || tick_o) pre_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) pre_q <= '0;
    else     pre_q <= pre_d;
  end

endmodule

// File: rtl/onewire_bit.sv
// Standard-speed 1-wire bit master: one reset/write/read slot per accepted command, one response per slot.
// cmd_ready is low from accept through the single-cycle DONE response; commands while busy are dropped.
module onewire_bit
  import onewire_pkg::*;
#(
  parameter int FRQ    = DEF_FRQ,
  parameter int T_RSTL = DEF_T_RSTL,
  parameter int T_PDS  = DEF_T_PDS,
  parameter int T_RSTH = DEF_T_RSTH,
  parameter int T_LOW0 = DEF_T_LOW0,
  parameter int T_LOW1 = DEF_T_LOW1,
  parameter int T_SMP  = DEF_T_SMP,
  parameter int T_SLOT = DEF_T_SLOT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic       cmd_pwr,
  output logic       rsp_valid,
  output logic       rsp_data,
  output logic       owr_p,
  output logic       owr_e,
  input  logic       owr_i
);

  localparam int CDR = FRQ / 1000000;

  localparam logic [US_W-1:0] US_RSTL = US_W'(T_RSTL);
  localparam logic [US_W-1:0] US_PDS  = US_W'(T_RSTL + T_PDS);
  localparam logic [US_W-1:0] US_RSTE = US_W'(T_RSTL + T_RSTH);
  localparam logic [US_W-1:0] US_LOW0 = US_W'(T_LOW0);
  localparam logic [US_W-1:0] US_LOW1 = US_W'(T_LOW1);
  localparam logic [US_W-1:0] US_SMP  = US_W'(T_SMP);
  localparam logic [US_W-1:0] US_SLOT = US_W'(T_SLOT);

  state_e          state_q, state_d;
  logic [US_W-1:0] us_q, us_d, us_nxt;
  logic [1:0]      op_q, op_d;
  logic            pwr_q, pwr_d;
  logic            owr_e_q, owr_e_d;
  logic            owr_p_q, owr_p_d;
  logic            rsp_data_q, rsp_data_d;
  logic [1:0]      sync_q;
  logic            sync_i;
  logic            accept;
  logic            tick;
  logic [US_W-1:0] low_pt, smp_pt, end_pt;

  // Idle bus reads high, so the synchronizer resets to 1.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], owr_i};
  end
  assign sync_i = sync_q[1];

  assign accept = cmd_valid && (state_q == ST_IDLE);

  onewire_clkdiv #(.CDR(CDR)) u_clkdiv (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (accept),
    .tick_o (tick)
  );

  always_comb begin
    low_pt = US_LOW1;
    smp_pt = US_SMP;
    end_pt = US_SLOT;
    case (op_q)
      OP_RST: begin
        low_pt = US_RSTL;
        smp_pt = US_PDS;
        end_pt = US_RSTE;
      end
      OP_WR0:  low_pt = US_LOW0;
      default: low_pt = US_LOW1;
    endcase
  end

  // Thresholds are matched against the value us_q takes at the wrap edge,
  // so an event at N us lands exactly N*CDR clocks after accept.
  assign us_nxt = us_q + US_W'(1);

  always_comb begin
    state_d    = state_q;
    us_d       = us_q;
    op_d       = op_q;
    pwr_d      = pwr_q;
    owr_e_d    = owr_e_q;
    owr_p_d    = owr_p_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d = ST_LOW;
          us_d    = '0;
          op_d    = cmd_op;
          pwr_d   = cmd_pwr;
          owr_e_d = 1'b1;
          owr_p_d = 1'b0;
        end
      end
      ST_LOW, ST_HIGH: begin
        if (tick) begin
          us_d = us_nxt;
          if (us_nxt == smp_pt) rsp_data_d = (op_q == OP_RST) ? ~sync_i : sync_i;
          if (state_q == ST_LOW && us_nxt == low_pt) begin
            owr_e_d = 1'b0;
            state_d = ST_HIGH;
          end
          if (state_q == ST_HIGH && us_nxt == end_pt) begin
            state_d = ST_DONE;
            owr_p_d = pwr_q;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      us_q       <= '0;
      op_q       <= OP_RST;
      pwr_q      <= 1'b0;
      owr_e_q    <= 1'b0;
      owr_p_q    <= 1'b0;
      rsp_data_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      us_q       <= us_d;
      op_q       <= op_d;
      pwr_q      <= pwr_d;
      owr_e_q    <= owr_e_d;
      owr_p_q    <= owr_p_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_DONE);
  assign rsp_data  = rsp_data_q;
  assign owr_e     = owr_e_q;
  assign owr_p     = owr_p_q;

endmodule

// File: tb/tb_onewire_bit.sv
// Bench for onewire_bit at 2 MHz: slot-level timing model, simple bus device, directed scenarios.
module tb_onewire_bit;
  import onewire_pkg::*;

  localparam int FRQ = 2000000;
  localparam int CDR = FRQ / 1000000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'd0;
  logic       cmd_pwr = 1'b0;
  logic       cmd_ready, rsp_valid, rsp_data, owr_p, owr_e;
  logic       owr_i;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  // Device: mode 0 absent, 1 presence pulse 20..200 us after a long reset low, 2 holds low 0..30 us of a slot.
  int dev_mode = 0;
  bit dev_low  = 1'b0;
  int dev_s = -1, dev_e = -1;
  assign owr_i = owr_p ? 1'b1 : ((owr_e || dev_low) ? 1'b0 : 1'b1);

  onewire_bit #(.FRQ(FRQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_pwr   (cmd_pwr),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .owr_p     (owr_p),
    .owr_e     (owr_e),
    .owr_i     (owr_i)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc++;

  int q_rise[$], q_fall[$], q_rv[$];
  bit q_rd[$];
  bit e_prev = 1'b0;
  always @(negedge clk) begin
    if (owr_e === 1'b1 && !e_prev) begin
      q_rise.push_back(cyc);
      if (dev_mode == 2) begin dev_s = cyc; dev_e = cyc + 30 * CDR; end
    end
    if (owr_e === 1'b0 && e_prev) begin
      q_fall.push_back(cyc);
      if (dev_mode == 1 && q_rise.size() > 0 && cyc - q_rise[$] >= 400 * CDR) begin
        dev_s = cyc + 20 * CDR;
        dev_e = cyc + 200 * CDR;
      end
    end
    e_prev = (owr_e === 1'b1);
    if (rsp_valid === 1'b1) begin
      q_rv.push_back(cyc);
      q_rd.push_back(rsp_data);
    end
    dev_low = (cyc >= dev_s && cyc < dev_e);
  end

  // Slot-level model in microseconds.
  function automatic int low_us(input int op);
    case (op)
      0: return 480;
      1: return 60;
      default: return 6;
    endcase
  endfunction

  function automatic int end_us(input int op);
    return (op == 0) ? 960 : 70;
  endfunction

  function automatic bit bus_low(input int op, input int mode, input int t);
    bit master, dev;
    master = (t < low_us(op));
    dev    = (mode == 1 && op == 0 && t >= 500 && t < 680) || (mode == 2 && t < 30);
    return master || dev;
  endfunction

  function automatic bit exp_bit(input int op, input int mode);
    if (op == 0) return bus_low(op, mode, 550);
    return !bus_low(op, mode, 15);
  endfunction

  bit m_busy = 1'b0, m_pwr = 1'b0, m_p = 1'b0;
  int m_n = 0, m_op = 0, m_mode = 0;
  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0;
      m_p    = 1'b0;
    end else if (m_busy) begin
      m_n++;
      if (m_n == end_us(m_op) * CDR) m_p = m_pwr;
      if (m_n > end_us(m_op) * CDR) m_busy = 1'b0;
    end else if (cmd_valid) begin
      m_busy = 1'b1;
      m_n    = 0;
      m_op   = int'(cmd_op);
      m_pwr  = cmd_pwr;
      m_mode = dev_mode;
      m_p    = 1'b0;
    end
  end

  always @(negedge clk) begin
    bit ee, ev;
    if (chk_en) begin
      ee = m_busy && (m_n < low_us(m_op) * CDR);
      ev = m_busy && (m_n == end_us(m_op) * CDR);
      chk("cmd_ready", 32'(cmd_ready), 32'(!m_busy));
      chk("owr_e", 32'(owr_e), 32'(ee));
      chk("owr_p", 32'(owr_p), 32'(m_p));
      chk("rsp_valid", 32'(rsp_valid), 32'(ev));
      chk("p_and_e", 32'(owr_p & owr_e), 32'd0);
      if (ev) chk("rsp_data", 32'(rsp_data), 32'(exp_bit(m_op, m_mode)));
    end
  end

  task automatic wait_ready();
    int t = 0;
    while (cmd_ready !== 1'b1 && t < 4000) begin @(negedge clk); t++; end
    chk("ready_timeout", 32'(cmd_ready), 32'd1);
  endtask

  task automatic issue(input logic [1:0] op, input bit pwr, input int mode);
    wait_ready();
    dev_mode  = mode;
    cmd_op    = op;
    cmd_pwr   = pwr;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rv(input int n);
    int t = 0;
    while (q_rv.size() < n && t < 4000) begin @(negedge clk); t++; end
    chk("rsp_timeout", 32'(q_rv.size() >= n), 32'd1);
  endtask

  initial begin
    int ir, iv;
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data", 32'(rsp_data), 32'd0);
    chk("reset_owr_e", 32'(owr_e), 32'd0);
    chk("reset_owr_p", 32'(owr_p), 32'd0);
    rst    = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // Reset with presence device
    ir = q_rise.size(); iv = q_rv.size();
    issue(OP_RST, 1'b0, 1);
    wait_rv(iv + 1);
    chk("rst1_low_len", 32'(q_fall[ir] - q_rise[ir]), 32'd960);
    chk("rst1_total", 32'(q_rv[iv] - q_rise[ir]), 32'd1920);
    chk("rst1_presence", 32'(q_rd[iv]), 32'd1);

    // Reset with empty bus
    ir = q_rise.size(); iv = q_rv.size();
    issue(OP_RST, 1'b0, 0);
    wait_rv(iv + 1);
    chk("rst0_low_len", 32'(q_fall[ir] - q_rise[ir]), 32'd960);
    chk("rst0_total", 32'(q_rv[iv] - q_rise[ir]), 32'd1920);
    chk("rst0_presence", 32'(q_rd[iv]), 32'd0);

    // WR0 then WR1 with cmd_valid held across both
    ir = q_rise.size(); iv = q_rv.size();
    wait_ready();
    dev_mode  = 0;
    cmd_pwr   = 1'b0;
    cmd_op    = OP_WR0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_op = OP_WR1;
    for (int t = 0; t < 1000 && q_rise.size() < ir + 2; t++) @(negedge clk);
    cmd_valid = 1'b0;
    wait_rv(iv + 2);
    chk("wr0_low_len", 32'(q_fall[ir] - q_rise[ir]), 32'd120);
    chk("wr1_low_len", 32'(q_fall[ir+1] - q_rise[ir+1]), 32'd12);
    chk("wr0_slot", 32'(q_rv[iv] - q_rise[ir]), 32'd140);
    chk("wr1_slot", 32'(q_rv[iv+1] - q_rise[ir+1]), 32'd140);
    chk("b2b_gap", 32'(q_rise[ir+1] - q_rv[iv]), 32'd2);
    chk("wr0_data", 32'(q_rd[iv]), 32'd0);
    chk("wr1_data", 32'(q_rd[iv+1]), 32'd1);

    // Reads: device holding low, then idle bus
    iv = q_rv.size();
    issue(OP_RD, 1'b0, 2);
    wait_rv(iv + 1);
    chk("rd_low_data", 32'(q_rd[iv]), 32'd0);
    iv = q_rv.size();
    issue(OP_RD, 1'b0, 0);
    wait_rv(iv + 1);
    chk("rd_idle_data", 32'(q_rd[iv]), 32'd1);

    // Strong pull-up after WR1, dropped on the next accept
    iv = q_rv.size();
    issue(OP_WR1, 1'b1, 0);
    wait_rv(iv + 1);
    @(negedge clk);
    chk("spu_idle_owr_p", 32'(owr_p), 32'd1);
    issue(OP_RD, 1'b0, 0);
    chk("spu_accept_owr_p", 32'(owr_p), 32'd0);
    chk("spu_accept_owr_e", 32'(owr_e), 32'd1);
    wait_rv(iv + 2);
    chk("spu_rd_data", 32'(q_rd[iv+1]), 32'd1);

    // Abort a reset slot 50 us in
    ir = q_rise.size(); iv = q_rv.size();
    issue(OP_RST, 1'b0, 0);
    repeat (50 * CDR - 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_owr_e", 32'(owr_e), 32'd0);
    chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (1900) @(negedge clk);
    chk("abort_no_rsp", 32'(q_rv.size()), 32'(iv));
    issue(OP_WR1, 1'b0, 0);
    wait_rv(iv + 1);
    chk("post_abort_slot", 32'(q_rv[iv] - q_rise[ir+1]), 32'd140);
    chk("post_abort_low", 32'(q_fall[ir+1] - q_rise[ir+1]), 32'd12);
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
